reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset-release controller that owns the design's async reset input. It synchronizes `async_rst` deassertion internally, then releases `NUM_STAGES` downstream reset domains one at a time, in index order. Each stage must acknowledge with `stage_ready` before the next stage is released. It sits at the top of the design, between the board reset pin and every block's reset input, and also services software-requested resets.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequenced reset outputs (2..16).
- `SYNC_DEPTH`, 2: synchronizer flops on `async_rst` deassertion (≥2).
- `STAGE_DELAY`, 16: cycles from stage i ready-sample to stage i+1 release (≥1).
- `TIMEOUT`, 255: cycles allowed from a stage's release to its `stage_ready` (≥1).
- `HOLD_CYCLES`, 8: cycles all resets are held after a software reset (≥1).

Ports:
- `clk`  in  1  single clock.
- `async_rst`  in  1  asynchronous, active-high reset.
- `sw_rst_req`  in  1  synchronous software reset request, level sampled each edge.
- `stage_ready`  in  NUM_STAGES  per-stage "out of reset and alive"; synchronous to `clk`.
- `stage_rst`  out  NUM_STAGES  active-high reset per stage.
- `seq_busy`  out  1  high whenever the FSM is not in DONE or ERROR.
- `all_ready`  out  1  all stages released and acknowledged.
- `timeout_err`  out  1  a stage failed to acknowledge within `TIMEOUT`.
- `err_stage`  out  $clog2(NUM_STAGES)  index of the failing stage.

## Operation
- Reset values while `async_rst` is high:
  - `stage_rst` all ones, asserted asynchronously.
  - `seq_busy`=1, `all_ready`=0, `timeout_err`=0, `err_stage`=0.
  - FSM in RST, all counters 0.
- FSM states and transitions:
  - RST: held until the synchronized reset deasserts, then go to REL with idx=0.
  - REL: clear `stage_rst[idx]`, load the timeout counter, go to WAIT.
  - WAIT: on `stage_ready[idx]`=1:
    - if idx is the last stage, go to DONE;
    - otherwise load the gap counter, increment idx, go to GAP.
  - GAP: count down `STAGE_DELAY`, then go to REL.
  - DONE: `all_ready` = registered AND of `stage_ready`. A falling ready clears `all_ready` only; it does not re-sequence.
  - ERROR: set `timeout_err`, capture `err_stage`=idx. Stages below idx stay released; stages at and above idx stay in reset. Exit only via `async_rst` or `sw_rst_req`.
  - HOLD: all `stage_rst` asserted for `HOLD_CYCLES`, then go to REL with idx=0 and `timeout_err` cleared.
- `sw_rst_req`=1 in any state except RST and HOLD: go to HOLD at the next edge. It overrides a simultaneous `stage_ready` or timeout expiry.
- `sw_rst_req` held high keeps the FSM in HOLD: the hold counter reloads each cycle.
- `stage_ready[j]` for j≠idx is ignored while sequencing.
- Counter width is `$clog2(max(STAGE_DELAY,TIMEOUT,HOLD_CYCLES)+1)`.

## Timing
- Edge 1 is the first rising edge that samples `async_rst` low.
- The synchronized reset falls at edge `SYNC_DEPTH`.
- `stage_rst[0]` falls after edge `SYNC_DEPTH`+1.
- `stage_ready[i]` sampled high at edge e → `stage_rst[i+1]` falls after edge e+`STAGE_DELAY`.
- Last-stage ready sampled at edge e → `all_ready`=1 and `seq_busy`=0 after edge e.
- No ready by edge r+`TIMEOUT` (r = release edge) → ERROR and `timeout_err`=1 after that edge.
- `sw_rst_req` sampled at edge s → all `stage_rst`=1 after edge s. `stage_rst[0]` falls after edge s+`HOLD_CYCLES`+1.
- `async_rst` mid-sequence: outputs return to reset values immediately, with no clock required.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `RST_SEQ_TIMEOUT_EN` defined:
  - timeout counter, ERROR state, `timeout_err` and `err_stage` are implemented as above.
- Not defined:
  - WAIT waits indefinitely and ERROR is unreachable.
  - `timeout_err` and `err_stage` are tied to 0.
  - `TIMEOUT` is unused.

## Structure
- Shared package `rst_seq_pkg` holds:
  - the state enum (RST, REL, WAIT, GAP, DONE, ERROR, HOLD);
  - the counter-width function.
- Sub-module `reset_sync_core`:
  - `SYNC_DEPTH`-flop chain;
  - asynchronous assertion, synchronous deassertion;
  - output drives the FSM hold in RST.

## Test plan
All scenarios use NUM_STAGES=4, SYNC_DEPTH=2, STAGE_DELAY=4, TIMEOUT=20, HOLD_CYCLES=8.
- Release `async_rst`, each `stage_ready[i]` rises 3 cycles after `stage_rst[i]` falls:
  - `stage_rst[0]` falls after edge 3, `[1]` after edge 10, `[2]` after edge 17, `[3]` after edge 24;
  - `all_ready`=1 after edge 27.
- `stage_ready[2]` never rises:
  - `timeout_err`=1 and `err_stage`=2 twenty cycles after the release of stage 2;
  - `stage_rst`=4'b1100 stays constant.
- `sw_rst_req` pulse in DONE:
  - `stage_rst`=4'b1111 next edge, `all_ready`=0;
  - `stage_rst[0]` falls 9 edges after the sample edge.
- `sw_rst_req` and `stage_ready[1]` on the same edge in WAIT: HOLD is entered and `stage_rst[2]` is never released.
- `async_rst` pulse lasting 5 ns mid-GAP, between edges: `stage_rst`=4'b1111 asynchronously, then the sequence restarts from stage 0.
- Compile without `RST_SEQ_TIMEOUT_EN`, ready withheld 500 cycles: `timeout_err` stays 0; releasing ready resumes the sequence.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and counter sizing for reset_sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_REL,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR,
    ST_HOLD
  } rst_seq_state_e;

  // One shared down-counter serves gap, timeout and hold, so size it for the largest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync_core.sv
// rtl/reset_sync_core.sv - reset synchronizer: asynchronous assert, synchronous release
module reset_sync_core #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic async_rst,
  output logic sync_rst
);

  logic [SYNC_DEPTH-1:0] r_sync;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], 1'b0};
    end
  end

  assign sync_rst = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with per-stage acknowledge and software reset
// Optional per-stage acknowledge timeout enabled by defining RST_SEQ_TIMEOUT_EN.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 255,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          async_rst,
  input  logic                          sw_rst_req,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_rst,
  output logic                          seq_busy,
  output logic                          all_ready,
  output logic                          timeout_err,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

  localparam int CW = cnt_width(STAGE_DELAY, TIMEOUT, HOLD_CYCLES);
  localparam int IW = $clog2(NUM_STAGES);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT - 1);
`else
  localparam logic [CW-1:0] TO_LOAD   = '0;
`endif
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  rst_seq_state_e        r_state, w_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_busy;
  logic                  r_all_ready;
  logic                  w_sync_rst;

  reset_sync_core #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk       (clk),
    .async_rst (async_rst),
    .sync_rst  (w_sync_rst)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    unique case (r_state)
      ST_RST: begin
        if (!w_sync_rst) begin
          w_nxt     = ST_REL;
          w_idx_nxt = '0;
        end
      end
      ST_REL: begin
`ifdef RST_SEQ_TIMEOUT_EN
        if (r_cnt == '0) begin
          w_nxt = ST_ERROR;
        end else begin
          w_nxt     = ST_WAIT;
          w_cnt_nxt = r_cnt - 1'b1;
        end
`else
        w_nxt = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        if (stage_ready[r_idx]) begin
          if (r_idx == LAST_IDX) begin
            w_nxt = ST_DONE;
          end else begin
            w_nxt     = ST_GAP;
            w_cnt_nxt = GAP_LOAD;
            w_idx_nxt = r_idx + 1'b1;
          end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_nxt = ST_ERROR;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (r_cnt == '0) w_nxt = ST_REL;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      ST_HOLD: begin
        if (sw_rst_req) begin
          w_cnt_nxt = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          w_nxt     = ST_REL;
          w_idx_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: ;
    endcase
    // Software reset wins over any acknowledge or timeout seen on the same edge.
    if (sw_rst_req && r_state != ST_RST && r_state != ST_HOLD) begin
      w_nxt     = ST_HOLD;
      w_cnt_nxt = HOLD_LOAD;
      w_idx_nxt = '0;
    end
    if (w_nxt == ST_REL) w_cnt_nxt = TO_LOAD;
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state     <= ST_RST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_busy      <= 1'b1;
      r_all_ready <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_nxt == ST_HOLD) begin
        r_stage_rst <= '1;
      end else if (w_nxt == ST_REL) begin
        r_stage_rst[w_idx_nxt] <= 1'b0;
      end else if (w_nxt == ST_ERROR && r_state != ST_ERROR) begin
        r_stage_rst[r_idx] <= 1'b1;
      end
      r_busy      <= !(w_nxt == ST_DONE || w_nxt == ST_ERROR);
      r_all_ready <= (w_nxt == ST_DONE) && (&stage_ready);
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  logic          r_timeout_err;
  logic [IW-1:0] r_err_stage;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_timeout_err <= 1'b0;
      r_err_stage   <= '0;
    end else if (w_nxt == ST_ERROR && r_state != ST_ERROR) begin
      r_timeout_err <= 1'b1;
      r_err_stage   <= r_idx;
    end else if (r_state == ST_HOLD && w_nxt == ST_REL) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
  assign err_stage   = r_err_stage;
`else
  assign timeout_err = 1'b0;
  assign err_stage   = '0;
`endif

  assign stage_rst = r_stage_rst;
  assign seq_busy  = r_busy;
  assign all_ready = r_all_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed edge-accurate bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] stage_ready = 4'b0000;
  logic [3:0] stage_rst;
  logic       seq_busy;
  logic       all_ready;
  logic       timeout_err;
  logic [1:0] err_stage;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int base = 0;

  reset_sequencer #(
    .NUM_STAGES (4),
    .SYNC_DEPTH (2),
    .STAGE_DELAY(4),
    .TIMEOUT    (20),
    .HOLD_CYCLES(8)
  ) dut (
    .clk        (clk),
    .async_rst  (async_rst),
    .sw_rst_req (sw_rst_req),
    .stage_ready(stage_ready),
    .stage_rst  (stage_rst),
    .seq_busy   (seq_busy),
    .all_ready  (all_ready),
    .timeout_err(timeout_err),
    .err_stage  (err_stage)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Park on the falling edge just after rising edge k (counted from first release).
  task automatic at(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  initial begin
    #1 async_rst = 1'b1;
    #1 check("async_assert_rst", stage_rst, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_stage_rst", stage_rst, 4'hF);
    check("rst_busy", seq_busy, 1'b1);
    check("rst_all_ready", all_ready, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_err_stage", err_stage, 2'd0);
    async_rst = 1'b0;
    base = cyc;

    at(2);  check("e2_held", stage_rst, 4'b1111);
    at(3);  check("e3_rel0", stage_rst, 4'b1110);
    at(5);  stage_ready = 4'b0001;
    at(9);  check("e9_gap", stage_rst, 4'b1110);
    at(10); check("e10_rel1", stage_rst, 4'b1100);
    at(12); stage_ready = 4'b0011;
    at(17); check("e17_rel2", stage_rst, 4'b1000);
    at(19); stage_ready = 4'b0111;
    at(24); check("e24_rel3", stage_rst, 4'b0000);
            check("e24_busy", seq_busy, 1'b1);
    at(26); stage_ready = 4'b1111;
            check("e26_not_ready", all_ready, 1'b0);
    at(27); check("e27_all_ready", all_ready, 1'b1);
            check("e27_busy", seq_busy, 1'b0);

    at(28); stage_ready = 4'b1101;
    at(29); check("drop_all_ready", all_ready, 1'b0);
            check("drop_no_reseq", stage_rst, 4'b0000);
            check("drop_busy", seq_busy, 1'b0);
            stage_ready = 4'b1111;
    at(30); check("restore_all_ready", all_ready, 1'b1);

    at(31); sw_rst_req = 1'b1;
    at(32); sw_rst_req = 1'b0;
            stage_ready = 4'b0000;
            check("sw_all_rst", stage_rst, 4'hF);
            check("sw_all_ready", all_ready, 1'b0);
            check("sw_busy", seq_busy, 1'b1);
    at(40); check("hold_s8", stage_rst, 4'hF);
    at(41); check("hold_rel0", stage_rst, 4'b1110);

    at(43); stage_ready = 4'b0001;
    at(48); check("seq2_rel1", stage_rst, 4'b1100);
    at(50); stage_ready = 4'b0011;
            sw_rst_req = 1'b1;
    at(51); sw_rst_req = 1'b0;
            stage_ready = 4'b0000;
            check("sw_beats_ready", stage_rst, 4'hF);
    at(55); check("no_rel2", stage_rst, 4'hF);
    at(60); check("hold2_rel0", stage_rst, 4'b1110);

    at(62); stage_ready = 4'b0001;
    at(63);
    @(posedge clk);
    #1 async_rst = 1'b1;
    #2;
    check("midgap_async_rst", stage_rst, 4'hF);
    check("midgap_busy", seq_busy, 1'b1);
    stage_ready = 4'b0000;
    #3 async_rst = 1'b0;
    at(66); check("restart_held", stage_rst, 4'hF);
    at(67); check("restart_rel0", stage_rst, 4'b1110);
    at(69); stage_ready = 4'b0001;
    at(74); check("restart_rel1", stage_rst, 4'b1100);

`ifdef RST_SEQ_TIMEOUT_EN
    at(76);  stage_ready = 4'b0011;
    at(81);  check("to_rel2", stage_rst, 4'b1000);
    at(100); check("to_not_yet", timeout_err, 1'b0);
             check("to_rst_pre", stage_rst, 4'b1000);
    at(101); check("to_err", timeout_err, 1'b1);
             check("to_err_stage", err_stage, 2'd2);
             check("to_busy", seq_busy, 1'b0);
             check("to_rst", stage_rst, 4'b1100);
    at(120); check("to_rst_stable", stage_rst, 4'b1100);
             check("to_err_sticky", timeout_err, 1'b1);
    at(121); sw_rst_req = 1'b1;
    at(122); sw_rst_req = 1'b0;
             stage_ready = 4'b0000;
             check("to_sw_rst", stage_rst, 4'hF);
    at(131); check("to_sw_rel0", stage_rst, 4'b1110);
             check("to_err_cleared", timeout_err, 1'b0);
`else
    at(574); check("noto_err", timeout_err, 1'b0);
             check("noto_err_stage", err_stage, 2'd0);
             check("noto_busy", seq_busy, 1'b1);
             check("noto_rst", stage_rst, 4'b1100);
    at(575); stage_ready = 4'b0011;
    at(579); check("noto_gap", stage_rst, 4'b1100);
    at(580); check("noto_rel2", stage_rst, 4'b1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
